// File: rtl/reg_arb_pkg.sv
// Shared constants and state type for the register-write arbiter.
package reg_arb_pkg;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned LOCK_MAX = 8;
    localparam int unsigned BURST_W  = $clog2(LOCK_MAX);

    typedef enum logic {
        IDLE,
        WRITE
    } state_e;

endpackage

// File: rtl/reg_wr_arbiter_rr_pick.sv
// Round-robin pick: first set req bit searched upward from (ptr+1) mod N_REQ.
import reg_arb_pkg::*;

module rr_pick (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       winner,
    output logic             any
);

    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!any && req[ptr + 2'(i)]) begin
                winner = ptr + 2'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter driving a shared register's write port; all outputs registered.
// Optional burst hold via lock is enabled by defining REG_ARB_LOCK_EN.
import reg_arb_pkg::*;

module reg_wr_arbiter #(
    parameter int unsigned DW = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ*DW-1:0] wd,
    output logic [N_REQ-1:0]    ack,
    output logic                reg_ce,
    output logic [DW-1:0]       reg_d,
    output logic [1:0]          gnt_id,
    output logic                busy
);

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              reg_ce_q, reg_ce_d;
    logic [DW-1:0]     reg_d_q, reg_d_d;
    logic [1:0]        gnt_id_q, gnt_id_d;
    logic              busy_q, busy_d;
    logic [1:0]        winner;
    logic              any;

    rr_pick u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

`ifdef REG_ARB_LOCK_EN
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               hold;

    assign hold = req[gnt_id_q] & lock[gnt_id_q] & (burst_q < BURST_W'(LOCK_MAX - 1));
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ack_d    = '0;
        reg_ce_d = 1'b0;
        reg_d_d  = reg_d_q;
        gnt_id_d = gnt_id_q;
        busy_d   = 1'b0;
`ifdef REG_ARB_LOCK_EN
        burst_d  = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d  = WRITE;
                    ptr_d    = winner;
                    ack_d    = N_REQ'(1) << winner;
                    reg_ce_d = 1'b1;
                    reg_d_d  = wd[int'(winner)*DW +: DW];
                    gnt_id_d = winner;
                    busy_d   = 1'b1;
                end
            end
            WRITE: begin
                state_d = IDLE;
`ifdef REG_ARB_LOCK_EN
                // Locked owner keeps the register; no arbitration until release.
                if (hold) begin
                    state_d  = WRITE;
                    ack_d    = N_REQ'(1) << gnt_id_q;
                    reg_ce_d = 1'b1;
                    reg_d_d  = wd[int'(gnt_id_q)*DW +: DW];
                    busy_d   = 1'b1;
                    burst_d  = burst_q + BURST_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd3;
            ack_q    <= '0;
            reg_ce_q <= 1'b0;
            reg_d_q  <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
`ifdef REG_ARB_LOCK_EN
            burst_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            reg_ce_q <= reg_ce_d;
            reg_d_q  <= reg_d_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
`ifdef REG_ARB_LOCK_EN
            burst_q  <= burst_d;
`endif
        end
    end

    assign ack    = ack_q;
    assign reg_ce = reg_ce_q;
    assign reg_d  = reg_d_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule
